// File: rtl/avalon_mem_burst_split_pkg.sv
// Shared types and helpers for the Avalon-MM burst splitter.
// No logic of its own; pure declarations.
// Not applicable: no handshake lives here.
package avalon_mem_burst_split_pkg;

   // Splitter FSM: idle/pass-through, issuing read sub-commands, streaming write beats
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_SPLIT = 2'd1,
      WR_BURST = 2'd2
   } t_split_state;

   // Length of the next sub-burst: whatever is left, capped at the memory-side limit
   function automatic int unsigned min_burst(input int unsigned rem, input int unsigned max_b);
      return (rem < max_b) ? rem : max_b;
   endfunction

endpackage

// File: rtl/avalon_mem_burst_split_rd_seq.sv
// Read-command sequencer: tracks address and lines left for the 2nd..Nth read sub-commands.
// Latency: outputs are straight from registers; state advances on each accepted sub-command.
// Backpressure: only moves when the top reports the current sub-command was accepted.
module avalon_mem_burst_split_rd_seq
   import avalon_mem_burst_split_pkg::*;
#(
   parameter int ADDR_WIDTH      = 27,
   parameter int AFU_BURST_WIDTH = 7,
   parameter int FIU_MAX_BURST   = 4,
   parameter int FIU_BURST_WIDTH = $clog2(FIU_MAX_BURST) + 1
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [ADDR_WIDTH-1:0]      start_addr,
   input  logic [AFU_BURST_WIDTH-1:0] start_count,
   input  logic                       advance,
   output logic [ADDR_WIDTH-1:0]      cur_addr,
   output logic [FIU_BURST_WIDTH-1:0] cur_burst,
   output logic                       last
);

   localparam logic [ADDR_WIDTH-1:0]      ADDR_STEP = ADDR_WIDTH'(FIU_MAX_BURST);
   localparam logic [AFU_BURST_WIDTH-1:0] MAX_AFU   = AFU_BURST_WIDTH'(FIU_MAX_BURST);

   logic [ADDR_WIDTH-1:0]      nxt_addr_q, nxt_addr_d;
   logic [AFU_BURST_WIDTH-1:0] rem_total_q, rem_total_d;

   assign cur_addr  = nxt_addr_q;
   assign cur_burst = FIU_BURST_WIDTH'(min_burst(32'(rem_total_q), FIU_MAX_BURST));
   assign last      = (rem_total_q <= MAX_AFU);

   // Load after the first (IDLE-issued) sub-command, then step per accepted sub-command
   always_comb begin
      nxt_addr_d  = nxt_addr_q;
      rem_total_d = rem_total_q;
      if (start) begin
         nxt_addr_d  = start_addr + ADDR_STEP;
         rem_total_d = start_count - MAX_AFU;
      end else if (advance) begin
         nxt_addr_d  = nxt_addr_q + ADDR_STEP;
         rem_total_d = rem_total_q - AFU_BURST_WIDTH'(cur_burst);
      end
   end

   // Sequencer registers
   always_ff @(posedge clk) begin
      if (reset) begin
         nxt_addr_q  <= '0;
         rem_total_q <= '0;
      end else begin
         nxt_addr_q  <= nxt_addr_d;
         rem_total_q <= rem_total_d;
      end
   end

endmodule

// File: rtl/avalon_mem_burst_split.sv
// Splits AFU Avalon-MM read/write bursts into memory-side sub-bursts of at most FIU_MAX_BURST beats.
// Latency: zero; command, write data and read responses are combinational paths.
// Backpressure: afu_waitrequest follows fiu_waitrequest, held high while read sub-commands are pending.
module avalon_mem_burst_split
   import avalon_mem_burst_split_pkg::*;
#(
   parameter int ADDR_WIDTH      = 27,
   parameter int DATA_WIDTH      = 512,
   parameter int AFU_BURST_WIDTH = 7,
   parameter int FIU_MAX_BURST   = 4,
   parameter int FIU_BURST_WIDTH = $clog2(FIU_MAX_BURST) + 1
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic [ADDR_WIDTH-1:0]      afu_address,
   input  logic [AFU_BURST_WIDTH-1:0] afu_burstcount,
   input  logic                       afu_read,
   input  logic                       afu_write,
   input  logic [DATA_WIDTH-1:0]      afu_writedata,
   input  logic [DATA_WIDTH/8-1:0]    afu_byteenable,
   output logic                       afu_waitrequest,
   output logic [DATA_WIDTH-1:0]      afu_readdata,
   output logic                       afu_readdatavalid,
   output logic [ADDR_WIDTH-1:0]      fiu_address,
   output logic [FIU_BURST_WIDTH-1:0] fiu_burstcount,
   output logic                       fiu_read,
   output logic                       fiu_write,
   output logic [DATA_WIDTH-1:0]      fiu_writedata,
   output logic [DATA_WIDTH/8-1:0]    fiu_byteenable,
   input  logic                       fiu_waitrequest,
   input  logic [DATA_WIDTH-1:0]      fiu_readdata,
   input  logic                       fiu_readdatavalid
);

   localparam logic [ADDR_WIDTH-1:0]      ADDR_STEP = ADDR_WIDTH'(FIU_MAX_BURST);
   localparam logic [AFU_BURST_WIDTH-1:0] MAX_AFU   = AFU_BURST_WIDTH'(FIU_MAX_BURST);

   t_split_state               state_q, state_d;
   logic [ADDR_WIDTH-1:0]      nxt_addr_q, nxt_addr_d;    // write path: start of next sub-burst
   logic [AFU_BURST_WIDTH-1:0] rem_total_q, rem_total_d;  // write path: beats still to pass
   logic [FIU_BURST_WIDTH-1:0] sub_left_q, sub_left_d;

   logic [FIU_BURST_WIDTH-1:0] afu_sub_burst;
   logic [FIU_BURST_WIDTH-1:0] wr_sub_burst;
   logic                       rd_start, rd_advance, rd_last;
   logic [ADDR_WIDTH-1:0]      rd_addr;
   logic [FIU_BURST_WIDTH-1:0] rd_burst;

   assign afu_sub_burst = FIU_BURST_WIDTH'(min_burst(32'(afu_burstcount), FIU_MAX_BURST));
   assign wr_sub_burst  = FIU_BURST_WIDTH'(min_burst(32'(rem_total_q), FIU_MAX_BURST));

   avalon_mem_burst_split_rd_seq #(
      .ADDR_WIDTH      (ADDR_WIDTH),
      .AFU_BURST_WIDTH (AFU_BURST_WIDTH),
      .FIU_MAX_BURST   (FIU_MAX_BURST),
      .FIU_BURST_WIDTH (FIU_BURST_WIDTH)
   ) u_rd_seq (
      .clk         (clk),
      .reset       (reset),
      .start       (rd_start),
      .start_addr  (afu_address),
      .start_count (afu_burstcount),
      .advance     (rd_advance),
      .cur_addr    (rd_addr),
      .cur_burst   (rd_burst),
      .last        (rd_last)
   );

   // Write data and read responses need no transformation; ordering is preserved end to end
   assign fiu_writedata     = afu_writedata;
   assign fiu_byteenable    = afu_byteenable;
   assign afu_readdata      = fiu_readdata;
   assign afu_readdatavalid = fiu_readdatavalid & ~reset;

   // Next-state and command generation
   always_comb begin
      state_d         = state_q;
      nxt_addr_d      = nxt_addr_q;
      rem_total_d     = rem_total_q;
      sub_left_d      = sub_left_q;
      rd_start        = 1'b0;
      rd_advance      = 1'b0;
      fiu_read        = 1'b0;
      fiu_write       = 1'b0;
      fiu_address     = afu_address;
      fiu_burstcount  = afu_sub_burst;
      afu_waitrequest = 1'b1;

      case (state_q)
         IDLE: begin
            // Write wins if both are asserted (protocol error, flagged below)
            if (afu_write) begin
               fiu_write       = 1'b1;
               afu_waitrequest = fiu_waitrequest;
               if (!fiu_waitrequest && (afu_burstcount > AFU_BURST_WIDTH'(1))) begin
                  state_d     = WR_BURST;
                  rem_total_d = afu_burstcount - AFU_BURST_WIDTH'(1);
                  sub_left_d  = afu_sub_burst - FIU_BURST_WIDTH'(1);
                  nxt_addr_d  = afu_address + ADDR_STEP;
               end
            end else if (afu_read) begin
               fiu_read = 1'b1;
               if (afu_burstcount <= MAX_AFU) begin
                  afu_waitrequest = fiu_waitrequest;
               end else if (!fiu_waitrequest) begin
                  // First sub-command taken; AFU command stays held until the last one
                  rd_start = 1'b1;
                  state_d  = RD_SPLIT;
               end
            end
         end

         RD_SPLIT: begin
            fiu_read       = 1'b1;
            fiu_address    = rd_addr;
            fiu_burstcount = rd_burst;
            rd_advance     = !fiu_waitrequest;
            if (rd_last) begin
               // Retire the AFU command on the same edge the final sub-command goes out
               afu_waitrequest = fiu_waitrequest;
               if (!fiu_waitrequest) begin
                  state_d = IDLE;
               end
            end
         end

         WR_BURST: begin
            fiu_write      = afu_write;
            fiu_address    = nxt_addr_q;
            fiu_burstcount = wr_sub_burst;
            if (afu_write) begin
               afu_waitrequest = fiu_waitrequest;
               if (!fiu_waitrequest) begin
                  rem_total_d = rem_total_q - AFU_BURST_WIDTH'(1);
                  if (sub_left_q == '0) begin
                     sub_left_d = wr_sub_burst - FIU_BURST_WIDTH'(1);
                     nxt_addr_d = nxt_addr_q + ADDR_STEP;
                  end else begin
                     sub_left_d = sub_left_q - FIU_BURST_WIDTH'(1);
                  end
                  if (rem_total_q == AFU_BURST_WIDTH'(1)) begin
                     state_d = IDLE;
                  end
               end
            end
         end

         default: state_d = IDLE;
      endcase

      // Nothing leaves the block and nothing is accepted while reset is held
      if (reset) begin
         fiu_read        = 1'b0;
         fiu_write       = 1'b0;
         afu_waitrequest = 1'b1;
      end
   end

   // FSM state and write-path counters
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         nxt_addr_q  <= '0;
         rem_total_q <= '0;
         sub_left_q  <= '0;
      end else begin
         state_q     <= state_d;
         nxt_addr_q  <= nxt_addr_d;
         rem_total_q <= rem_total_d;
         sub_left_q  <= sub_left_d;
      end
   end

`ifndef SYNTHESIS
   // AFU protocol errors: read and write together, or a zero-length burst
   a_no_rd_wr_together: assert property (@(posedge clk) disable iff (reset)
      (state_q == IDLE) |-> !(afu_read && afu_write));
   a_no_zero_burst: assert property (@(posedge clk) disable iff (reset)
      ((state_q == IDLE) && (afu_read || afu_write)) |-> (afu_burstcount != '0));
`endif

endmodule
